debug_cmd_ctrl: RTL and testbench

Host-command sequencer for the MIPS debug path. It pops command bytes from the UART receive FIFO and gates the pipeline clock enable to run continuously or single-step. It counts executed cycles and triggers a full state dump through the debug dump unit at each stop point. It sits between the UART RX FIFO, the pipeline enable/reset inputs and the dump unit's `readRegs` trigger.

---
 rtl/debug_pkg.sv | 37 +++
 rtl/sat_counter.sv | 36 +++
 rtl/debug_cmd_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_debug_cmd_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : debug_pkg
//  Brief    : Shared constants, state encoding and helpers for the MIPS
//             debug command sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package debug_pkg;

   // Width of the executed-cycle counter
   localparam int DATA_W = 32;

   // Default host command bytes (ASCII)
   localparam logic [7:0] DEF_CMD_RUN   = 8'h43;  // 'C'
   localparam logic [7:0] DEF_CMD_STEP  = 8'h53;  // 'S'
   localparam logic [7:0] DEF_CMD_NEXT  = 8'h4E;  // 'N'
   localparam logic [7:0] DEF_CMD_RESET = 8'h52;  // 'R'

   // One-hot sequencer states
   typedef enum logic [7:0] {
      S_IDLE      = 8'b0000_0001,
      S_RUN       = 8'b0000_0010,
      S_STEP_WAIT = 8'b0000_0100,
      S_STEP_EXEC = 8'b0000_1000,
      S_DUMP_REQ  = 8'b0001_0000,
      S_DUMP_WAIT = 8'b0010_0000,
      S_DONE      = 8'b0100_0000,
      S_RST       = 8'b1000_0000
   } state_t;

   // States in which a host byte may be consumed from the RX FIFO
   function automatic logic accepts_cmd(input state_t s);
      return (s == S_IDLE) || (s == S_STEP_WAIT) || (s == S_DONE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Brief    : Up-counter with synchronous clear, optional load, enable and
//             saturation at all-ones (never wraps).
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] MAX_VAL = '1;

   // Clear has priority, then load, then a saturating increment
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != MAX_VAL)) begin
         count <= count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/debug_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : debug_cmd_ctrl
//  Brief    : Host-command sequencer for the MIPS debug path. Pops command
//             bytes from the UART RX FIFO, gates the pipeline clock enable
//             (run / single-step), counts enabled cycles and triggers a
//             state dump at every stop point.
//  Revision : 1.0 - initial release
// ============================================================================
module debug_cmd_ctrl
   import debug_pkg::*;
#(
   parameter logic [7:0] CMD_RUN      = DEF_CMD_RUN,
   parameter logic [7:0] CMD_STEP     = DEF_CMD_STEP,
   parameter logic [7:0] CMD_NEXT     = DEF_CMD_NEXT,
   parameter logic [7:0] CMD_RESET    = DEF_CMD_RESET,
   parameter int         RST_CYCLES   = 4,
   parameter int         DUMP_TIMEOUT = 65535
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              rx_empty,
   input  logic [7:0]        rx_data,
   output logic              rd_uart,
   input  logic              halt,
   output logic              cpu_en,
   output logic              cpu_rst,
   output logic              dump_req,
   input  logic              dump_done,
   output logic [DATA_W-1:0] iterations,
   output logic              mode_step,
   output logic              dump_err
);

   localparam int                TMO_W    = (DUMP_TIMEOUT > 1) ? $clog2(DUMP_TIMEOUT) : 1;
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(DUMP_TIMEOUT - 1);
   localparam logic [3:0]        RST_LAST = 4'(RST_CYCLES - 1);

   state_t            state;
   state_t            state_nx;
   logic              mode_nx;
   logic              last;
   logic              last_nx;
   logic              err_set;
   logic              iter_clr;
   logic              pop;
   logic              tmo_hit;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [3:0]        rst_cnt;

   // A byte is consumed only in a command-accepting state with data present
   assign pop     = accepts_cmd(state) && !rx_empty;
   // Expiry is evaluated in the last permitted DUMP_WAIT cycle
   assign tmo_hit = (state == S_DUMP_WAIT) && (tmo_cnt == TMO_LAST);

   // State, step-mode, halt-seen and sticky error registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= S_IDLE;
         mode_step <= 1'b0;
         last      <= 1'b0;
         dump_err  <= 1'b0;
      end else begin
         state     <= state_nx;
         mode_step <= mode_nx;
         last      <= last_nx;
         if (err_set) begin
            dump_err <= 1'b1;
         end
      end
   end

   // Dump timeout and soft-reset pulse counters run only inside their states
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         tmo_cnt <= '0;
         rst_cnt <= '0;
      end else begin
         tmo_cnt <= (state == S_DUMP_WAIT) ? tmo_cnt + 1'b1 : '0;
         rst_cnt <= (state == S_RST)       ? rst_cnt + 1'b1 : '0;
      end
   end

   // Next-state decode and Moore/Mealy output generation
   always_comb begin
      state_nx = state;
      mode_nx  = mode_step;
      last_nx  = last;
      err_set  = 1'b0;
      iter_clr = 1'b0;
      cpu_en   = (state == S_RUN) || (state == S_STEP_EXEC);
      cpu_rst  = (state == S_RST);
      dump_req = (state == S_DUMP_REQ);
      rd_uart  = pop && !RESET;

      case (state)
         S_IDLE: begin
            if (pop) begin
               if (rx_data == CMD_RUN) begin
                  state_nx = S_RUN;
                  mode_nx  = 1'b0;
                  iter_clr = 1'b1;
               end else if (rx_data == CMD_STEP) begin
                  state_nx = S_STEP_WAIT;
                  mode_nx  = 1'b1;
                  iter_clr = 1'b1;
               end else if (rx_data == CMD_RESET) begin
                  state_nx = S_RST;
               end
            end
         end
         S_RUN: begin
            if (halt) begin
               state_nx = S_DUMP_REQ;
               last_nx  = 1'b1;
            end
         end
         S_STEP_WAIT: begin
            if (pop) begin
               if (rx_data == CMD_NEXT) begin
                  state_nx = S_STEP_EXEC;
               end else if (rx_data == CMD_RUN) begin
                  state_nx = S_RUN;
                  mode_nx  = 1'b0;
               end else if (rx_data == CMD_RESET) begin
                  state_nx = S_RST;
               end
            end
         end
         S_STEP_EXEC: begin
            last_nx  = halt;
            state_nx = S_DUMP_REQ;
         end
         S_DUMP_REQ: begin
            state_nx = S_DUMP_WAIT;
         end
         S_DUMP_WAIT: begin
            // A done pulse in the expiry cycle wins over the timeout
            if (dump_done || tmo_hit) begin
               err_set = !dump_done;
               if (last) begin
                  state_nx = S_DONE;
               end else if (mode_step) begin
                  state_nx = S_STEP_WAIT;
               end else begin
                  state_nx = S_IDLE;
               end
            end
         end
         S_DONE: begin
            if (pop && (rx_data == CMD_RESET)) begin
               state_nx = S_RST;
            end
         end
         S_RST: begin
            mode_nx  = 1'b0;
            last_nx  = 1'b0;
            iter_clr = 1'b1;
            if (rst_cnt == RST_LAST) begin
               state_nx = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   sat_counter #(
      .WIDTH (DATA_W)
   ) u_iter_cnt (
      .CLK      (CLK),
      .RESET    (RESET),
      .clr      (iter_clr),
      .load     (1'b0),
      .load_val ({DATA_W{1'b0}}),
      .en       (cpu_en),
      .count    (iterations)
   );

endmodule
`default_nettype wire

// File: tb/tb_debug_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_debug_cmd_ctrl
//  Brief    : Self-checking bench for debug_cmd_ctrl: behavioural model with
//             per-cycle compare plus directed scenarios with literal results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_debug_cmd_ctrl;

   localparam int TMO  = 16;
   localparam int RSTC = 4;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        rx_empty = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        halt = 1'b0;
   logic        dump_done = 1'b0;
   logic        rd_uart, cpu_en, cpu_rst, dump_req, mode_step, dump_err;
   logic [31:0] iterations;

   // standalone counter for the saturation corner
   logic        sc_clr = 1'b0, sc_load = 1'b0, sc_en = 1'b0;
   logic [31:0] sc_val = 32'h0;
   logic [31:0] sc_count;

   always #5 CLK = ~CLK;

   debug_cmd_ctrl #(
      .RST_CYCLES   (RSTC),
      .DUMP_TIMEOUT (TMO)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .rx_empty   (rx_empty),
      .rx_data    (rx_data),
      .rd_uart    (rd_uart),
      .halt       (halt),
      .cpu_en     (cpu_en),
      .cpu_rst    (cpu_rst),
      .dump_req   (dump_req),
      .dump_done  (dump_done),
      .iterations (iterations),
      .mode_step  (mode_step),
      .dump_err   (dump_err)
   );

   sat_counter #(.WIDTH(32)) u_sc (
      .CLK      (CLK),
      .RESET    (RESET),
      .clr      (sc_clr),
      .load     (sc_load),
      .load_val (sc_val),
      .en       (sc_en),
      .count    (sc_count)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
   endtask

   // ---------------- RX FIFO (first-word fall-through) ----------------
   logic [7:0] fifo[$];
   logic [7:0] push_log[$];
   int         push_idx = 0;
   bit         rd_q = 1'b0;

   always @(posedge CLK) begin
      #2;
      if (rd_q && fifo.size() != 0) fifo.delete(0);
      while (push_idx < push_log.size()) begin
         fifo.push_back(push_log[push_idx]);
         push_idx++;
      end
      rx_empty = (fifo.size() == 0);
      rx_data  = rx_empty ? 8'h00 : fifo[0];
   end

   // ---------------- dump unit responder ----------------
   bit resp_en    = 1'b1;
   int resp_delay = 12;
   int resp_cnt   = 0;

   always @(negedge CLK) begin
      dump_done = 1'b0;
      if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) dump_done = 1'b1;
      end
      if (dump_req && resp_en) resp_cnt = resp_delay;
   end

   // ---------------- behavioural model ----------------
   localparam int P_IDLE = 0, P_RUN = 1, P_SW = 2, P_EXEC = 3,
                  P_DREQ = 4, P_DWAIT = 5, P_DONE = 6, P_RST = 7;
   int     m_phase = P_IDLE;
   longint m_iter  = 0;
   bit     m_mode = 1'b0, m_last = 1'b0, m_err = 1'b0;
   int     m_wait = 0, m_rleft = 0;

   function automatic bit m_listening(input int p);
      return (p == P_IDLE) || (p == P_SW) || (p == P_DONE);
   endfunction

   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         m_phase = P_IDLE; m_iter = 0; m_mode = 1'b0; m_last = 1'b0; m_err = 1'b0;
         m_wait = 0; m_rleft = 0;
      end else begin
         automatic bit         got = m_listening(m_phase) && (fifo.size() != 0);
         automatic logic [7:0] b   = got ? fifo[0] : 8'h00;
         automatic int         nxt = m_phase;
         if ((m_phase == P_RUN || m_phase == P_EXEC) && m_iter < 64'h0000_0000_FFFF_FFFF)
            m_iter++;
         case (m_phase)
            P_IDLE: if (got) begin
               if (b == 8'h43)      begin nxt = P_RUN; m_iter = 0; m_mode = 1'b0; end
               else if (b == 8'h53) begin nxt = P_SW;  m_iter = 0; m_mode = 1'b1; end
               else if (b == 8'h52) begin nxt = P_RST; m_rleft = RSTC; end
            end
            P_RUN: if (halt) begin nxt = P_DREQ; m_last = 1'b1; end
            P_SW: if (got) begin
               if (b == 8'h4E)      nxt = P_EXEC;
               else if (b == 8'h43) begin nxt = P_RUN; m_mode = 1'b0; end
               else if (b == 8'h52) begin nxt = P_RST; m_rleft = RSTC; end
            end
            P_EXEC: begin m_last = halt; nxt = P_DREQ; end
            P_DREQ: begin nxt = P_DWAIT; m_wait = 0; end
            P_DWAIT: begin
               m_wait++;
               if (dump_done || m_wait == TMO) begin
                  if (!dump_done) m_err = 1'b1;
                  nxt = m_last ? P_DONE : (m_mode ? P_SW : P_IDLE);
               end
            end
            P_DONE: if (got && b == 8'h52) begin nxt = P_RST; m_rleft = RSTC; end
            P_RST: begin
               m_iter = 0; m_mode = 1'b0; m_last = 1'b0;
               m_rleft--;
               if (m_rleft == 0) nxt = P_IDLE;
            end
            default: nxt = P_IDLE;
         endcase
         m_phase = nxt;
      end
   end

   // ---------------- per-cycle compare and pulse counters ----------------
   int cnt_en = 0, cnt_rise = 0, cnt_req = 0, cnt_rst = 0, cnt_rd = 0;
   bit prev_en = 1'b0;

   always @(negedge CLK) begin
      automatic bit e_rd = m_listening(m_phase) && (fifo.size() != 0) && !RESET;
      automatic bit e_en = (m_phase == P_RUN) || (m_phase == P_EXEC);
      check("cycle {rd,en,rst,req,mode,err,iter}",
            {26'h0, rd_uart, cpu_en, cpu_rst, dump_req, mode_step, dump_err, iterations},
            {26'h0, e_rd, e_en, (m_phase == P_RST), (m_phase == P_DREQ), m_mode, m_err, m_iter[31:0]});
      rd_q = rd_uart;
      if (cpu_en) cnt_en++;
      if (cpu_en && !prev_en) cnt_rise++;
      prev_en = cpu_en;
      if (dump_req) cnt_req++;
      if (cpu_rst)  cnt_rst++;
      if (rd_uart)  cnt_rd++;
   end

   // ---------------- sequencing helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #3;
   endtask

   task automatic push(input logic [7:0] b);
      push_log.push_back(b);
   endtask

   task automatic wait_rest(input int maxc, input string name);
      automatic bit ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         tick(1);
         if (fifo.size() == 0 && push_idx == push_log.size() && m_listening(m_phase)
             && resp_cnt == 0 && !dump_done) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, {63'h0, ok}, 64'h1);
   endtask

   task automatic wait_en(input int maxc, input string name);
      automatic bit ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         tick(1);
         if (cpu_en) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, {63'h0, ok}, 64'h1);
   endtask

   // ---------------- directed scenarios ----------------
   int b_rd, b_en, b_req, b_rst, b_rise;

   initial begin
      RESET = 1'b1;
      tick(3);
      check("reset_outputs", {rd_uart, cpu_en, cpu_rst, dump_req, mode_step, dump_err, iterations}, 64'h0);
      RESET = 1'b0;
      tick(2);

      // unknown byte in IDLE: popped, ignored
      b_rd = cnt_rd;
      push(8'h41);
      tick(4);
      check("ignored_pop", cnt_rd - b_rd, 1);
      check("ignored_state", {cpu_en, mode_step, iterations}, 0);

      // run to halt, with a blocked 'S' arriving mid-run
      b_rd = cnt_rd; b_en = cnt_en; b_req = cnt_req;
      resp_en = 1'b1; resp_delay = 12;
      push(8'h43);
      wait_en(10, "run_start");
      push(8'h53);
      tick(10);
      check("run_blocked_pop", cnt_rd - b_rd, 1);
      halt = 1'b1;
      wait_rest(80, "run_settle");
      check("run_iterations", iterations, 11);
      check("run_en_cycles", cnt_en - b_en, 11);
      check("run_dump_reqs", cnt_req - b_req, 1);
      check("run_late_pop", cnt_rd - b_rd, 2);
      tick(5);
      check("done_no_en", cnt_en - b_en, 11);
      halt = 1'b0;

      // soft reset from DONE
      b_rd = cnt_rd; b_rst = cnt_rst;
      push(8'h52);
      wait_rest(40, "rst_settle");
      check("rst_pulse_len", cnt_rst - b_rst, RSTC);
      check("rst_iterations", iterations, 0);
      check("rst_pops", cnt_rd - b_rd, 1);

      // step mode: S N N N
      b_en = cnt_en; b_req = cnt_req; b_rise = cnt_rise;
      push(8'h53); push(8'h4E); push(8'h4E); push(8'h4E);
      wait_rest(200, "step_settle");
      check("step_en_cycles", cnt_en - b_en, 3);
      check("step_en_pulses", cnt_rise - b_rise, 3);
      check("step_dump_reqs", cnt_req - b_req, 3);
      check("step_iterations", iterations, 3);
      check("step_mode", mode_step, 1);

      // done arriving in the expiry cycle is not a timeout
      resp_delay = TMO;
      push(8'h4E);
      wait_rest(80, "edge_settle");
      check("edge_no_err", dump_err, 0);
      check("edge_iterations", iterations, 4);

      // no done at all: timeout, error, back to STEP_WAIT
      resp_en = 1'b0;
      push(8'h4E);
      wait_rest(80, "tmo_settle");
      check("tmo_err", dump_err, 1);
      check("tmo_mode", mode_step, 1);

      // halt seen during a step ends in DONE
      resp_en = 1'b1; resp_delay = 5;
      halt = 1'b1;
      push(8'h4E);
      wait_rest(60, "step_halt_settle");
      halt = 1'b0;
      check("step_halt_iter", iterations, 6);
      b_en = cnt_en;
      push(8'h4E);
      tick(6);
      check("done_ignores_next", cnt_en - b_en, 0);
      push(8'h52);
      wait_rest(40, "rst2_settle");
      check("err_survives_rst", dump_err, 1);

      // halt already high when RUN is entered
      halt = 1'b1;
      b_en = cnt_en;
      push(8'h43);
      wait_rest(60, "prehalt_settle");
      check("prehalt_en_cycles", cnt_en - b_en, 1);
      check("prehalt_iter", iterations, 1);
      halt = 1'b0;
      push(8'h52);
      wait_rest(40, "rst3_settle");

      // asynchronous reset in the middle of a run
      push(8'h43);
      wait_en(10, "run2_start");
      tick(5);
      #1 RESET = 1'b1;
      #1 check("async_reset_outs", {rd_uart, cpu_en, cpu_rst, dump_req, mode_step, dump_err, iterations}, 64'h0);
      tick(2);
      RESET = 1'b0;
      tick(3);
      check("post_reset_idle", {cpu_en, iterations}, 0);

      // saturation of the iteration counter
      sc_val = 32'hFFFF_FFFE; sc_load = 1'b1;
      tick(1);
      sc_load = 1'b0;
      check("sat_preload", sc_count, 32'hFFFF_FFFE);
      sc_en = 1'b1;
      tick(1);
      check("sat_reach_max", sc_count, 32'hFFFF_FFFF);
      tick(4);
      check("sat_hold_max", sc_count, 32'hFFFF_FFFF);
      sc_clr = 1'b1;
      tick(1);
      check("sat_clear", sc_count, 32'h0);
      sc_clr = 1'b0; sc_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
